// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD number formatter.
// Line type, ASCII constants, FSM states, BCD helpers.
package lcd_pkg;

  typedef logic [0:15][7:0] lcd_line_t;
  typedef logic [0:3][7:0]  lcd_label_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam lcd_label_t LBL_DEC = "DEC:";
  localparam lcd_label_t LBL_HEX = "HEX:";

  localparam lcd_line_t BLANK_LINE = {16{ASCII_SPACE}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FORMAT
  } fmt_state_t;

  // Add 3 to every BCD nibble that is 5 or more.
  function automatic logic [39:0] bcd_adjust(
    input logic [39:0] b
  );
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] hex_ascii(
    input logic [3:0] h
  );
    if (h < 4'd10)
      return ASCII_ZERO + {4'h0, h};
    else
      return ASCII_A + {4'h0, h} - 8'd10;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 10-digit BCD converter.
// One double-dabble step per cycle, 32 steps total.
module bin2bcd_seq
  import lcd_pkg::*;
(
  input  logic        iCLK_50,
  input  logic        iRST_N,
  input  logic        iStart,
  input  logic [31:0] iBin,
  output logic [39:0] oBcd,
  output logic        oDone
);

  logic [31:0] bin_q;
  logic [39:0] bcd_q;
  logic [39:0] adj;
  logic [4:0]  cnt;
  logic        busy;

  assign adj   = bcd_adjust(bcd_q);
  assign oBcd  = bcd_q;
  // High during the cycle whose edge performs the last step.
  assign oDone = busy && (cnt == 5'd31);

  // Load on start, then adjust-and-shift until 32 steps are done.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (iStart) begin
      bin_q <= iBin;
      bcd_q <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      bcd_q <= {adj[38:0], bin_q[31]};
      bin_q <= {bin_q[30:0], 1'b0};
      cnt   <= cnt + 5'd1;
      if (cnt == 5'd31)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_num_format.sv
// Formats a 32-bit value as decimal and hex LCD lines.
// Handshake, ASCII mapping, blanking, line registers.
module lcd_num_format
  import lcd_pkg::*;
#(
  parameter bit LEADING_ZERO = 1'b0
) (
  input  logic        iCLK_50,
  input  logic        iRST_N,
  input  logic        iLoad,
  input  logic [31:0] iValue,
  output logic        oReady,
  output lcd_line_t   oString0,
  output lcd_line_t   oString1,
  output logic        oUpdate
);

  fmt_state_t  state;
  logic [31:0] hex_q;
  logic [39:0] bcd;
  logic        done;
  logic        start;
  lcd_line_t   line0_d;
  lcd_line_t   line1_d;
  logic        lead;
  logic [3:0]  dig;

  assign oReady = (state == ST_IDLE);
  assign start  = oReady && iLoad;

  bin2bcd_seq u_bcd (
    .iCLK_50 (iCLK_50),
    .iRST_N  (iRST_N),
    .iStart  (start),
    .iBin    (iValue),
    .oBcd    (bcd),
    .oDone   (done)
  );

  // Build both lines from the finished BCD and the hex copy.
  always_comb begin
    line0_d      = BLANK_LINE;
    line1_d      = BLANK_LINE;
    line0_d[0:3] = LBL_DEC;
    line1_d[0:3] = LBL_HEX;
    lead         = !LEADING_ZERO;
    dig          = '0;
    for (int i = 0; i < 10; i++) begin
      dig = bcd[39-4*i -: 4];
      if (lead && dig == 4'd0 && i < 9) begin
        line0_d[6+i] = ASCII_SPACE;
      end else begin
        lead         = 1'b0;
        line0_d[6+i] = ASCII_ZERO + {4'h0, dig};
      end
    end
    for (int i = 0; i < 8; i++)
      line1_d[8+i] = hex_ascii(hex_q[31-4*i -: 4]);
  end

  // Control FSM with registered lines and update pulse.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      hex_q    <= '0;
      oString0 <= BLANK_LINE;
      oString1 <= BLANK_LINE;
      oUpdate  <= 1'b0;
    end else begin
      oUpdate <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (iLoad) begin
            hex_q <= iValue;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (done)
            state <= ST_FORMAT;
        end
        ST_FORMAT: begin
          oString0 <= line0_d;
          oString1 <= line1_d;
          oUpdate  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_num_format.sv
// Bench for lcd_num_format: table vectors, random values
// against an arithmetic model, and handshake corner cases.
module tb_lcd_num_format;
  import lcd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] value;
  logic        rdy_a, rdy_b;
  logic        upd_a, upd_b;
  lcd_line_t   s0_a, s1_a, s0_b, s1_b;

  int vectors;
  int miscompares;

  lcd_num_format #(.LEADING_ZERO(1'b0)) dut_a (
    .iCLK_50  (clk),
    .iRST_N   (rst_n),
    .iLoad    (load),
    .iValue   (value),
    .oReady   (rdy_a),
    .oString0 (s0_a),
    .oString1 (s1_a),
    .oUpdate  (upd_a)
  );

  lcd_num_format #(.LEADING_ZERO(1'b1)) dut_b (
    .iCLK_50  (clk),
    .iRST_N   (rst_n),
    .iLoad    (load),
    .iValue   (value),
    .oReady   (rdy_b),
    .oString0 (s0_b),
    .oString1 (s1_b),
    .oUpdate  (upd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    lcd_line_t   dec_blank;
    lcd_line_t   dec_keep;
    lcd_line_t   hex;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic lcd_line_t model_dec(input logic [31:0] v,
                                          input bit keep);
    lcd_line_t l;
    longint unsigned x;
    x = v;
    l = {16{8'h20}};
    l[0:3] = "DEC:";
    for (int p = 15; p >= 6; p--) begin
      l[p] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    if (!keep) begin
      for (int p = 6; p < 15; p++) begin
        if (l[p] != 8'h30) break;
        l[p] = 8'h20;
      end
    end
    return l;
  endfunction

  function automatic lcd_line_t model_hex(input logic [31:0] v);
    lcd_line_t l;
    longint unsigned x;
    longint unsigned n;
    x = v;
    l = {16{8'h20}};
    l[0:3] = "HEX:";
    for (int p = 15; p >= 8; p--) begin
      n = x % 16;
      l[p] = (n < 10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
      x = x / 16;
    end
    return l;
  endfunction

  task automatic do_load(input logic [31:0] v);
    chk("ready_before_load", {rdy_a, rdy_b}, 2'b11);
    load  = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Waits for the update pulse after an accepted load.
  // inject != 0 pulses iLoad with 999 ten cycles in.
  task automatic wait_update(input bit inject, output int k_seen);
    lcd_line_t p0, p1;
    bit busy_ok, hold_ok;
    p0 = s0_a;
    p1 = s1_a;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    k_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (upd_a || upd_b) begin
        k_seen = k;
        break;
      end
      if (rdy_a || rdy_b) busy_ok = 1'b0;
      if (s0_a !== p0 || s1_a !== p1) hold_ok = 1'b0;
      if (inject && k == 10) begin
        load  = 1'b1;
        value = 32'd999;
      end
      if (inject && k == 11) load = 1'b0;
    end
    chk("latency", k_seen, 33);
    chk("both_update", {upd_a, upd_b}, 2'b11);
    chk("busy_not_ready", busy_ok, 1'b1);
    chk("strings_hold", hold_ok, 1'b1);
  endtask

  task automatic chk_lines(input logic [31:0] v);
    chk("dec_blank", s0_a, model_dec(v, 1'b0));
    chk("dec_keep", s0_b, model_dec(v, 1'b1));
    chk("hex_a", s1_a, model_hex(v));
    chk("hex_b", s1_b, model_hex(v));
  endtask

  task automatic chk_single_pulse();
    @(posedge clk);
    #1;
    chk("pulse_single", {upd_a, upd_b}, 2'b00);
  endtask

  initial begin
    int k;
    logic [31:0] v;
    bit spurious;

    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{32'd0,
               "DEC:           0",
               "DEC:  0000000000",
               "HEX:    00000000"};
    tbl[1] = '{32'hFFFFFFFF,
               "DEC:  4294967295",
               "DEC:  4294967295",
               "HEX:    FFFFFFFF"};
    tbl[2] = '{32'd42,
               "DEC:          42",
               "DEC:  0000000042",
               "HEX:    0000002A"};
    tbl[3] = '{32'd12345,
               "DEC:       12345",
               "DEC:  0000012345",
               "HEX:    00003039"};
    tbl[4] = '{32'd1000000000,
               "DEC:  1000000000",
               "DEC:  1000000000",
               "HEX:    3B9ACA00"};

    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_str0", s0_a, {16{8'h20}});
    chk("rst_str1", s1_b, {16{8'h20}});
    chk("rst_ready", {rdy_a, rdy_b}, 2'b11);
    chk("rst_update", {upd_a, upd_b}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      do_load(tbl[i].val);
      wait_update(1'b0, k);
      chk("tbl_dec_blank", s0_a, tbl[i].dec_blank);
      chk("tbl_dec_keep", s0_b, tbl[i].dec_keep);
      chk("tbl_hex", s1_a, tbl[i].hex);
      chk("tbl_hex_b", s1_b, tbl[i].hex);
      chk_single_pulse();
    end

    for (int i = 0; i < 24; i++) begin
      v = $urandom;
      if (i % 3 == 0) v = $urandom_range(0, 99999);
      if (i % 7 == 0) v = $urandom_range(0, 9);
      do_load(v);
      wait_update(1'b0, k);
      chk_lines(v);
      chk_single_pulse();
    end

    // Busy load ignored, load during update cycle accepted.
    do_load(32'd12345);
    wait_update(1'b1, k);
    chk_lines(32'd12345);
    load  = 1'b1;
    value = 32'd7;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("pulse_not_double", {upd_a, upd_b}, 2'b00);
    chk("accept_in_update", {rdy_a, rdy_b}, 2'b00);
    wait_update(1'b0, k);
    chk_lines(32'd7);
    chk_single_pulse();

    // Reset in the middle of a conversion.
    do_load(32'hDEADBEEF);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_str0", s0_a, {16{8'h20}});
    chk("midrst_str1", s1_a, {16{8'h20}});
    chk("midrst_str0_b", s0_b, {16{8'h20}});
    chk("midrst_ready", {rdy_a, rdy_b}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (upd_a || upd_b) spurious = 1'b1;
    end
    chk("midrst_no_update", spurious, 1'b0);
    chk("midrst_ready_after", {rdy_a, rdy_b}, 2'b11);
    chk("midrst_str_after", s1_b, {16{8'h20}});

    do_load(32'd305419896);
    wait_update(1'b0, k);
    chk_lines(32'd305419896);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_num_format.md
# lcd_num_format

- Upstream producer for the 16x2 character LCD line writer.
- Accepts a 32-bit unsigned value through a ready/valid handshake. Converts it to decimal ASCII with an iterative double-dabble, and to hexadecimal ASCII.
- Presents two registered 16-character lines, `oString0` and `oString1`. The LCD line writer consumes these directly.
- Both lines update atomically, once per accepted value.

## Interface

Parameters:
- `LEADING_ZERO`, default 0: 0 replaces leading decimal zeros with spaces; 1 keeps all 10 decimal digits.

Ports:
- `iCLK_50`  in  1  single clock, rising edge.
- `iRST_N`  in  1  reset, asynchronous, active-low.
- `iLoad`  in  1  value valid; accepted only when `oReady`=1.
- `iValue`  in  32  unsigned value, sampled on acceptance.
- `oReady`  out  1  high in IDLE; decoded from state.
- `oString0`  out  [0:15][7:0]  line 1 text; index 0 is the leftmost character.
- `oString1`  out  [0:15][7:0]  line 2 text.
- `oUpdate`  out  1  one-cycle pulse when new strings are valid.

## Operation

State machine: IDLE -> SHIFT -> FORMAT -> IDLE.
- **IDLE:** `oReady`=1. On `iLoad`, latch `iValue` into the shift register and the hex copy, clear the 40-bit BCD register and the 5-bit bit counter, then go to SHIFT.
- **SHIFT:** one double-dabble step per cycle, 32 cycles.
  - First, each 4-bit BCD nibble ≥5 gets +3 (all 10 nibbles in parallel).
  - Then shift {bcd, bin} left by 1.
  - Counter increments; counter = 31 goes to FORMAT.
- **FORMAT:** write both strings in one cycle, pulse `oUpdate`, return to IDLE.

Line 1 (`oString0`) layout:
- Chars 0-3: "DEC:".
- Chars 4-5: space (0x20).
- Chars 6-15: 10 decimal digits, most significant first. Digits are 0x30+d.

Line 2 (`oString1`) layout:
- Chars 0-3: "HEX:".
- Chars 4-7: space.
- Chars 8-15: 8 hex digits, most significant first. 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase).

Blanking (`LEADING_ZERO`=0):
- Every zero digit left of the first nonzero digit becomes 0x20.
- Char 15 is never blanked.
- Hex digits are never blanked.

Boundary conditions:
- `iLoad` while `oReady`=0 is ignored; no queueing, no error.
- `iLoad` in the same cycle as the `oUpdate` pulse is accepted, because state is IDLE then.
- Strings hold their last value during conversion. They change only on the edge that asserts `oUpdate`.
- BCD arithmetic: 10 nibbles are sufficient (max 4294967295). No overflow is possible, so no saturation logic exists.
- Reset mid-conversion: the conversion is discarded, strings return to all spaces, and no `oUpdate` is produced.

## Timing

- Reset values: `oString0` and `oString1` all 0x20; `oUpdate`=0; state IDLE, so `oReady`=1; internal registers 0.
- Latency: `iLoad` accepted at edge N.
  - SHIFT occupies edges N+1..N+32.
  - FORMAT registers the strings at edge N+33, with `oUpdate`=1 for exactly that cycle.
- `oReady` is low from after edge N until edge N+33.
- Throughput: one value per 33 cycles.
- `oUpdate` is never high for two consecutive cycles.

## Structure

Shared package `lcd_pkg` holds:
- `typedef logic [0:15][7:0] lcd_line_t`.
- Constants `ASCII_SPACE`=8'h20, `ASCII_ZERO`=8'h30, `ASCII_A`=8'h41.
- Label constants "DEC:" and "HEX:".
- State enum `fmt_state_t`.

Sub-module `bin2bcd_seq`:
- Iterative 32-bit to 10-digit BCD converter.
- Ports: `iStart`, `iBin[31:0]`, `oBcd[39:0]`, `oDone` (one-cycle pulse).
- `lcd_num_format` wraps it, adds the handshake, ASCII mapping, blanking and the output line registers.

## Test plan

1. **Reset:** assert `iRST_N`=0 mid-simulation -> strings all 0x20, `oReady`=1, `oUpdate`=0.
2. **Zero:** `iValue`=0, `LEADING_ZERO`=0 -> 33 cycles later:
   - line 1 = "DEC:" + 11 spaces + "0";
   - line 2 = "HEX:    00000000";
   - exactly one `oUpdate` pulse.
3. **Maximum:** `iValue`=32'hFFFFFFFF -> "DEC:  4294967295" / "HEX:    FFFFFFFF".
4. **Leading zeros kept:** `LEADING_ZERO`=1, `iValue`=42 -> "DEC:  0000000042" / "HEX:    0000002A".
5. **Busy load ignored, back-to-back accepted:**
   - load 12345, then `iLoad` with 999 ten cycles later -> result "DEC:       12345" / "HEX:    00003039", and 999 never appears.
   - then `iLoad`=1 with 7 during the `oUpdate` cycle -> accepted; 7 is shown 33 cycles later.
6. **Reset mid-conversion:** `iRST_N` low at SHIFT cycle 20 -> strings spaces, no `oUpdate`, `oReady`=1 after release.
